pc_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 23 ++
 rtl/return_addr_stack.sv | 60 ++++++
 rtl/pc_unit.sv | 137 +++++++++++++
 tb/tb_pc_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: address width, redirect kinds and the
// opcode encodings that the branch logic and the PC stage agree on.
package cpu_pkg;

    localparam int ADDR_W_DEF = 16;

    typedef enum logic [2:0] {
        RD_NONE,
        RD_BRANCH,
        RD_JUMP,
        RD_CALL,
        RD_RET
    } redirect_e;

    localparam logic [3:0] OPC_BEQ  = 4'h0;
    localparam logic [3:0] OPC_BNE  = 4'h1;
    localparam logic [3:0] OPC_BLT  = 4'h2;
    localparam logic [3:0] OPC_BGE  = 4'h3;
    localparam logic [3:0] OPC_JMP  = 4'h4;
    localparam logic [3:0] OPC_CALL = 4'h5;
    localparam logic [3:0] OPC_RET  = 4'h6;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: pushing onto a full stack overwrites the
// oldest entry, so the newest RAS_DEPTH return addresses are always kept.
module return_addr_stack
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] push_data_i,
    output logic [ADDR_W-1:0] top_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // ptr_q is the next free slot; when full it also addresses the oldest entry
    assign full_o     = (cnt_q == CNT_MAX);
    assign empty_o    = (cnt_q == '0);
    assign top_data_o = mem_q[ptr_q - PTR_ONE];

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_i) begin
            ptr_d = ptr_q + PTR_ONE;
            if (!full_o) cnt_d = cnt_q + CNT_ONE;
        end else if (pop_i && !empty_o) begin
            ptr_d = ptr_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !rst) mem_q[ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC stage with priority redirect mux, flush pulse and RAS error flags.
// Optional macro PC_PERF_CNT_EN adds saturating redirect/ret counters.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter int                RAS_DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              pc_branch_sel_in,
    input  logic [ADDR_W-1:0] branch_target_in,
    input  logic              jump_in,
    input  logic              call_in,
    input  logic              ret_in,
    input  logic [ADDR_W-1:0] jump_target_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic              flush_out,
    output logic              ras_overflow_out,
    output logic              ras_underflow_out
`ifdef PC_PERF_CNT_EN
    ,
    output logic [15:0]       redirect_cnt_out,
    output logic [15:0]       ret_cnt_out
`endif
);

    redirect_e         sel;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic              flush_q, flush_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              ras_push, ras_pop, ras_full, ras_empty;
    logic [ADDR_W-1:0] ras_top;

    assign pc_inc = pc_q + ADDR_W'(1);

    // Stall masks every request, which also forces flush low and holds the flags
    always_comb begin
        sel = RD_NONE;
        if (!stall_in) begin
            if (ret_in)                sel = RD_RET;
            else if (call_in)          sel = RD_CALL;
            else if (jump_in)          sel = RD_JUMP;
            else if (pc_branch_sel_in) sel = RD_BRANCH;
        end
    end

    always_comb begin
        pc_d     = pc_inc;
        flush_d  = (sel != RD_NONE);
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        case (sel)
            RD_NONE:   if (stall_in) pc_d = pc_q;
            RD_BRANCH: pc_d = branch_target_in;
            RD_JUMP:   pc_d = jump_target_in;
            RD_CALL: begin
                pc_d     = jump_target_in;
                ras_push = 1'b1;
                if (ras_full) ovf_d = 1'b1;
            end
            RD_RET: begin
                if (ras_empty) begin
                    unf_d = 1'b1;
                end else begin
                    pc_d    = ras_top;
                    ras_pop = 1'b1;
                end
            end
            default: pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            flush_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            flush_q <= flush_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    return_addr_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_inc),
        .top_data_o  (ras_top),
        .full_o      (ras_full),
        .empty_o     (ras_empty)
    );

    assign pc_out            = pc_q;
    assign flush_out         = flush_q;
    assign ras_overflow_out  = ovf_q;
    assign ras_underflow_out = unf_q;

`ifdef PC_PERF_CNT_EN
    logic [15:0] redir_cnt_q, redir_cnt_d;
    logic [15:0] ret_cnt_q, ret_cnt_d;

    always_comb begin
        redir_cnt_d = redir_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        if (sel != RD_NONE && redir_cnt_q != 16'hFFFF) redir_cnt_d = redir_cnt_q + 16'd1;
        if (sel == RD_RET && ret_cnt_q != 16'hFFFF)    ret_cnt_d   = ret_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redir_cnt_q <= '0;
            ret_cnt_q   <= '0;
        end else begin
            redir_cnt_q <= redir_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

    assign redirect_cnt_out = redir_cnt_q;
    assign ret_cnt_out      = ret_cnt_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: each driven cycle queues its expected PC,
// flush and flag values, which are popped and compared after the clock edge.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic        pc_branch_sel_in;
    logic [15:0] branch_target_in;
    logic        jump_in;
    logic        call_in;
    logic        ret_in;
    logic [15:0] jump_target_in;
    logic [15:0] pc_out;
    logic        flush_out;
    logic        ras_overflow_out;
    logic        ras_underflow_out;
`ifdef PC_PERF_CNT_EN
    logic [15:0] redirect_cnt_out;
    logic [15:0] ret_cnt_out;
`endif

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic        flush;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .ADDR_W       (16),
        .RAS_DEPTH    (4),
        .RESET_VECTOR (16'h0000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_in          (stall_in),
        .pc_branch_sel_in  (pc_branch_sel_in),
        .branch_target_in  (branch_target_in),
        .jump_in           (jump_in),
        .call_in           (call_in),
        .ret_in            (ret_in),
        .jump_target_in    (jump_target_in),
        .pc_out            (pc_out),
        .flush_out         (flush_out),
        .ras_overflow_out  (ras_overflow_out),
        .ras_underflow_out (ras_underflow_out)
`ifdef PC_PERF_CNT_EN
        ,
        .redirect_cnt_out  (redirect_cnt_out),
        .ret_cnt_out       (ret_cnt_out)
`endif
    );

    task automatic idle();
        rst              = 1'b0;
        stall_in         = 1'b0;
        pc_branch_sel_in = 1'b0;
        branch_target_in = 16'h0;
        jump_in          = 1'b0;
        call_in          = 1'b0;
        ret_in           = 1'b0;
        jump_target_in   = 16'h0;
    endtask

    // Queue the expectation for the inputs now applied, clock once, then compare
    task automatic step(input string name, input logic [15:0] pc, input logic flush,
                        input logic ovf, input logic unf);
        exp_t e;
        e.name = name; e.pc = pc; e.flush = flush; e.ovf = ovf; e.unf = unf;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        checks++;
        if (pc_out !== e.pc) begin
            failures++;
            $display("[TB] FAIL %s pc: got %h expected %h", e.name, pc_out, e.pc);
        end
        checks++;
        if (flush_out !== e.flush) begin
            failures++;
            $display("[TB] FAIL %s flush: got %b expected %b", e.name, flush_out, e.flush);
        end
        checks++;
        if (ras_overflow_out !== e.ovf) begin
            failures++;
            $display("[TB] FAIL %s overflow: got %b expected %b", e.name, ras_overflow_out, e.ovf);
        end
        checks++;
        if (ras_underflow_out !== e.unf) begin
            failures++;
            $display("[TB] FAIL %s underflow: got %b expected %b", e.name, ras_underflow_out, e.unf);
        end
        idle();
    endtask

    task automatic doReset();
        idle();
        rst = 1'b1;
        step("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    // Jump to addr-1 then run one sequential cycle so pc=addr with flush clear
    task automatic gotoPc(input logic [15:0] addr);
        jump_in = 1'b1; jump_target_in = addr - 16'd1;
        step("goto_jump", addr - 16'd1, 1'b1, ras_overflow_out, ras_underflow_out);
        step("goto_seq", addr, 1'b0, ras_overflow_out, ras_underflow_out);
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rst = 1'b1;
            step("reset_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 1; i <= 3; i++) step("free_run", 16'(i), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_branch();
        doReset();
        for (int i = 1; i <= 5; i++) step("br_pre", 16'(i), 1'b0, 1'b0, 1'b0);
        pc_branch_sel_in = 1'b1; branch_target_in = 16'h0040;
        step("branch", 16'h0040, 1'b1, 1'b0, 1'b0);
        step("branch_after", 16'h0041, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_call_ret();
        doReset();
        gotoPc(16'd10);
        call_in = 1'b1; jump_target_in = 16'd100;
        step("call1", 16'd100, 1'b1, 1'b0, 1'b0);
        step("call1_seq", 16'd101, 1'b0, 1'b0, 1'b0);
        call_in = 1'b1; jump_target_in = 16'd200;
        step("call2", 16'd200, 1'b1, 1'b0, 1'b0);
        ret_in = 1'b1;
        step("ret1", 16'd102, 1'b1, 1'b0, 1'b0);
        ret_in = 1'b1;
        step("ret2", 16'd11, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_overflow_underflow();
        logic [15:0] retExp [4];
        doReset();
        for (int i = 1; i <= 5; i++) begin
            call_in = 1'b1; jump_target_in = 16'(i * 16'h100);
            step("call_n", 16'(i * 16'h100), 1'b1, (i == 5), 1'b0);
        end
        retExp = '{16'h0401, 16'h0301, 16'h0201, 16'h0101};
        for (int i = 0; i < 4; i++) begin
            ret_in = 1'b1;
            step("ret_n", retExp[i], 1'b1, 1'b1, 1'b0);
        end
        ret_in = 1'b1;
        step("ret_underflow", 16'h0102, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_priority_stall();
        doReset();
        call_in = 1'b1; jump_target_in = 16'h0050;
        step("prio_call", 16'h0050, 1'b1, 1'b0, 1'b0);
        step("prio_seq", 16'h0051, 1'b0, 1'b0, 1'b0);
        ret_in = 1'b1; call_in = 1'b1; jump_target_in = 16'h0099;
        pc_branch_sel_in = 1'b1; branch_target_in = 16'h0077;
        step("prio_ret_wins", 16'h0001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stall_in = 1'b1; jump_in = 1'b1; jump_target_in = 16'h0333;
            step("stall", 16'h0001, 1'b0, 1'b0, 1'b0);
        end
        step("stall_release", 16'h0002, 1'b0, 1'b0, 1'b0);
        ret_in = 1'b1;
        step("prio_ras_empty", 16'h0003, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back_wrap_reset();
        doReset();
        gotoPc(16'hFFFF);
        step("wrap", 16'h0000, 1'b0, 1'b0, 1'b0);
        call_in = 1'b1; jump_target_in = 16'h0030;
        step("midop_call", 16'h0030, 1'b1, 1'b0, 1'b0);
        rst = 1'b1; call_in = 1'b1; jump_target_in = 16'h0060;
        step("reset_over_call", 16'h0000, 1'b0, 1'b0, 1'b0);
        ret_in = 1'b1;
        step("ret_after_reset", 16'h0001, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        idle();
        test_reset();
        test_branch();
        test_call_ret();
        test_overflow_underflow();
        test_priority_stall();
        test_back_to_back_wrap_reset();
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
